// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

   typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

   localparam int RF_ZERO_REG = 0;

   function automatic int rf_aw(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy scoreboard for in-flight register writes
// Optional same-cycle write bypass of rbusy under REGFILE_BYPASS_EN.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int NWR   = 1,
   parameter int NRD   = 2,
   parameter int AW    = rf_aw(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              alloc_valid,
   input  logic [AW-1:0]     alloc_addr,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] wa,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD-1:0]    rbusy
);

   localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

   logic [NREGS-1:0] busy;
   logic [AW-1:0]    rsel;
   logic             wr_hit;

   // The alloc is assigned last so it overrides a same-cycle write clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else if (run) begin
         for (int p = 0; p < NWR; p++) begin
            if (we[p]) busy[wa[p*AW +: AW]] <= 1'b0;
         end
         if (alloc_valid && alloc_addr != ZERO) busy[alloc_addr] <= 1'b1;
      end
   end

   always_comb begin
      rbusy  = '0;
      rsel   = '0;
      wr_hit = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         rsel   = ra[i*AW +: AW];
         wr_hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p*AW +: AW] == rsel) wr_hit = 1'b1;
         end
         if (alloc_valid && alloc_addr == rsel) wr_hit = 1'b0;
`endif
         rbusy[i] = run && (rsel != ZERO) && busy[rsel] && !wr_hit;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with clear sweep and scoreboard
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   parameter  int NWR   = 1,
   localparam int AW    = rf_aw(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   output logic [NRD-1:0]      rbusy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_addr
);

   localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_REG);

   logic [XLEN-1:0] rf [NREGS];
   rf_state_e       state;
   logic [AW-1:0]   idx;
   logic            run;
   logic [AW-1:0]   rsel;
   logic [XLEN-1:0] rval;

   assign run = (state == RF_RUN);

   // Register 0 is never swept: reads of x0 are forced to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RF_CLEAR;
         idx   <= AW'(1);
         ready <= 1'b0;
      end else if (state == RF_CLEAR) begin
         idx <= idx + 1'b1;
         if (idx == AW'(NREGS - 1)) begin
            state <= RF_RUN;
            ready <= 1'b1;
         end
      end
   end

   // Ascending port order lets the highest-index port win an address conflict.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == RF_CLEAR) begin
            rf[idx] <= '0;
         end else begin
            for (int p = 0; p < NWR; p++) begin
               if (we[p] && wa[p*AW +: AW] != ZERO)
                  rf[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
            end
         end
      end
   end

   always_comb begin
      rd   = '0;
      rsel = '0;
      rval = '0;
      for (int i = 0; i < NRD; i++) begin
         rsel = ra[i*AW +: AW];
         rval = rf[rsel];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p*AW +: AW] == rsel) rval = wd[p*XLEN +: XLEN];
         end
`endif
         if (!run || rsel == ZERO) rval = '0;
         rd[i*XLEN +: XLEN] = rval;
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR),
      .NRD   (NRD),
      .AW    (AW)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .we          (we),
      .wa          (wa),
      .ra          (ra),
      .rbusy       (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (NRD=2, NWR=2)
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic [1:0]  rbusy;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic        alloc_valid;
   logic [4:0]  alloc_addr;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] mmem [32];
   bit          mbusy [32];
   bit          mrdy;
   int          mcnt;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        av;
      logic [4:0]  aa;
      logic [4:0]  ra0, ra1;
      logic [31:0] e0, e1;
      logic [1:0]  eb;
   } vec_t;

   vec_t tbl [16];

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .ready       (ready),
      .ra          (ra),
      .rd          (rd),
      .rbusy       (rbusy),
      .we          (we),
      .wa          (wa),
      .wd          (wd),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic av, input logic [4:0] aa,
                        input logic [4:0] r0, input logic [4:0] r1);
      reset = rst; we = w; wa = {a1, a0}; wd = {d1, d0};
      alloc_valid = av; alloc_addr = aa; ra = {r1, r0};
   endtask

   // Reference model: the whole file is zero from reset on, and traffic is
   // ignored until NREGS-1 edges have elapsed.
   task automatic model_edge();
      if (reset) begin
         mrdy = 1'b0;
         mcnt = 0;
         for (int r = 0; r < 32; r++) begin mmem[r] = '0; mbusy[r] = 1'b0; end
      end else if (!mrdy) begin
         mcnt++;
         if (mcnt == 31) mrdy = 1'b1;
      end else begin
         if (we[0]) begin if (wa[4:0] != 0) mmem[wa[4:0]] = wd[31:0];  mbusy[wa[4:0]] = 1'b0; end
         if (we[1]) begin if (wa[9:5] != 0) mmem[wa[9:5]] = wd[63:32]; mbusy[wa[9:5]] = 1'b0; end
         if (alloc_valid && alloc_addr != 0) mbusy[alloc_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (!mrdy || a == 0) return 32'h0;
      v = mmem[a];
      if (BYP) begin
         if (we[1] && wa[9:5] == a) v = wd[63:32];
         else if (we[0] && wa[4:0] == a) v = wd[31:0];
      end
      return v;
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      bit written;
      if (!mrdy || a == 0) return 1'b0;
      written = (we[0] && wa[4:0] == a) || (we[1] && wa[9:5] == a);
      if (BYP && written && !(alloc_valid && alloc_addr == a)) return 1'b0;
      return mbusy[a];
   endfunction

   task automatic check_model();
      check("ready", {63'h0, ready}, {63'h0, mrdy});
      check("rd0", {32'h0, rd[31:0]},  {32'h0, exp_rd(ra[4:0])});
      check("rd1", {32'h0, rd[63:32]}, {32'h0, exp_rd(ra[9:5])});
      check("rbusy", {62'h0, rbusy}, {62'h0, exp_busy(ra[9:5]), exp_busy(ra[4:0])});
   endtask

   // Sweep with write/alloc traffic that must be ignored; ready must take 31 edges.
   task automatic sweep(input string tag);
      int cnt = 0;
      while (cnt < 100) begin
         drive(1'b0, 2'b11, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), $urandom, $urandom,
               1'b1, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         #1;
         if (ready === 1'b1) break;
         check({tag, "_rd"}, rd, 64'h0);
         check({tag, "_rbusy"}, {62'h0, rbusy}, 64'h0);
         tick();
         cnt++;
      end
      check({tag, "_len"}, 64'(cnt), 64'd31);
   endtask

   initial begin
      tbl[0]  = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00};
      tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
      tbl[2]  = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 2'b00};
      tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 2'b00};
      tbl[4]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, BYP ? 32'h22 : 32'h0, BYP ? 32'h22 : 32'h0, 2'b00};
      tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h22, 32'h0, 2'b00};
      tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 2'b00};
      tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 2'b11};
      tbl[8]  = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, BYP ? 32'h99 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01};
      tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h99, 32'h0, 2'b00};
      tbl[10] = '{2'b10, 5'd0, 5'd9, 32'h0, 32'hAB, 1'b1, 5'd9, 5'd9, 5'd0, BYP ? 32'hAB : 32'h99, 32'h0, 2'b00};
      tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'hAB, 32'h0, 2'b01};
      tbl[12] = '{2'b01, 5'd3, 5'd0, 32'hA5, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0, BYP ? 32'hA5 : 32'h0, 2'b00};
      tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0, 32'hA5, 2'b00};
      tbl[14] = '{2'b01, 5'd4, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3, BYP ? 32'h55 : 32'h0, 32'hA5, 2'b00};
      tbl[15] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9, 32'h55, 32'hAB, 2'b10};

      // Power-on reset and clear sweep
      drive(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      check("reset_ready", {63'h0, ready}, 64'h0);
      sweep("sweep1");
      for (int r = 0; r < 32; r += 2) begin
         drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(r + 1));
         #1;
         check("clear_rd", rd, 64'h0);
         check("clear_rbusy", {62'h0, rbusy}, 64'h0);
         tick();
      end

      // Directed vectors
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
               tbl[i].av, tbl[i].aa, tbl[i].ra0, tbl[i].ra1);
         #1;
         check($sformatf("tbl%0d_ready", i), {63'h0, ready}, 64'h1);
         check($sformatf("tbl%0d_rd0", i), {32'h0, rd[31:0]}, {32'h0, tbl[i].e0});
         check($sformatf("tbl%0d_rd1", i), {32'h0, rd[63:32]}, {32'h0, tbl[i].e1});
         check($sformatf("tbl%0d_rbusy", i), {62'h0, rbusy}, {62'h0, tbl[i].eb});
         tick();
      end

      // Mid-run reset with reg 4 written and reg 9 busy
      drive(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
      tick();
      drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
      #1;
      check("mid_reset_ready", {63'h0, ready}, 64'h0);
      check("mid_reset_rbusy", {62'h0, rbusy}, 64'h0);
      sweep("sweep2");
      drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9);
      #1;
      check("post_reset_rd4", {32'h0, rd[31:0]}, 64'h0);
      check("post_reset_rbusy9", {62'h0, rbusy}, 64'h0);
      tick();

      // Randomized traffic against the model, small address range for conflicts
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom_range(0, 299) == 0), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         #1;
         check_model();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
